// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dm_port_arbiter
//  Purpose  : Shares the single-port, word-wide data memory between the CPU
//             M-stage (port 0) and the DMA/debug master (port 1). Arbitrates
//             between the ports, sequences each access, and turns partial
//             (byte-enabled) writes into a read-modify-write because the
//             memory only accepts whole-word writes.
//  Ports    : clk, reset (synchronous, active-high)
//             m0_req/we/be/addr/wdata/pc -> m0_rdata/m0_ack   (CPU M-stage)
//             m1_req/we/be/addr/wdata    -> m1_rdata/m1_ack   (DMA/debug)
//             mem_addr/mem_wdata/mem_we  -> memory, mem_rdata <- memory
//             err  : pulses with ack for an out-of-range access
//             busy : high whenever an access is in flight
//  Options  : DM_ARB_WRITE_LOG_EN - print every memory write (simulation)
//  Revision : 1.0 - initial release
// ============================================================================
module dm_port_arbiter #(
    parameter int MEM_WORDS    = 3072,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m0_pc,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,

    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,

    output logic        err,
    output logic        busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]  C_ST_IDLE      = 2'd0;
    localparam logic [1:0]  C_ST_ACCESS    = 2'd1;
    localparam logic [1:0]  C_ST_MERGE_WR  = 2'd2;
    localparam logic [1:0]  C_ST_DONE      = 2'd3;

    localparam logic [29:0] C_MEM_WORDS    = 30'(MEM_WORDS);
    localparam logic [3:0]  C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]  state_q,      state_d;
    logic        port_q,       port_d;      // 0: M-stage, 1: DMA/debug
    logic        we_q,         we_d;
    logic [3:0]  be_q,         be_d;
    logic [11:0] addr_q,       addr_d;      // word address into the memory
    logic        oor_q,        oor_d;       // access is out of range
    logic [31:0] wdata_q,      wdata_d;
    logic [31:0] rdata_q,      rdata_d;
    logic [31:0] merge_q,      merge_d;     // read-modify-write result
    logic [3:0]  starve_cnt_q, starve_cnt_d;

    // ------------------------------------------------------------------------
    // Arbitration and winner selection
    // ------------------------------------------------------------------------
    logic        w_any_req;
    logic        w_grant1;
    logic        w_granting;
    logic        w_sel_we;
    logic [3:0]  w_sel_be;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_oor;

    assign w_any_req  = m0_req | m1_req;
    // Port 0 has priority unless port 1 has already waited out its budget.
    assign w_grant1   = m1_req & (~m0_req | (starve_cnt_q == C_STARVE_LIMIT));
    assign w_granting = (state_q == C_ST_IDLE) & w_any_req;

    assign w_sel_we    = w_grant1 ? m1_we    : m0_we;
    assign w_sel_be    = w_grant1 ? m1_be    : m0_be;
    assign w_sel_addr  = w_grant1 ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_grant1 ? m1_wdata : m0_wdata;
    assign w_sel_oor   = (w_sel_addr[31:2] >= C_MEM_WORDS);

    // Byte-lane offset bits never reach the word-wide memory.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^w_sel_addr[1:0];

    // ------------------------------------------------------------------------
    // Byte classification of the latched request
    // ------------------------------------------------------------------------
    logic w_be_full;
    logic w_be_zero;
    logic w_be_partial;

    assign w_be_full    = (be_q == 4'hF);
    assign w_be_zero    = (be_q == 4'h0);
    assign w_be_partial = ~w_be_full & ~w_be_zero;

    // Enabled bytes come from the write data, the rest from the current word.
    logic [31:0] w_merged;

    for (genvar i = 0; i < 4; i++) begin : g_merge_byte
        assign w_merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_rdata[8*i +: 8];
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        oor_d        = oor_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        merge_d      = merge_q;
        starve_cnt_d = starve_cnt_q;

        case (state_q)
            C_ST_IDLE: begin
                if (w_any_req) begin
                    port_d  = w_grant1;
                    we_d    = w_sel_we;
                    be_d    = w_sel_be;
                    addr_d  = w_sel_addr[13:2];
                    oor_d   = w_sel_oor;
                    wdata_d = w_sel_wdata;
                    state_d = C_ST_ACCESS;
                end
            end

            C_ST_ACCESS: begin
                // Writes and out-of-range reads return zero data.
                rdata_d = (~we_q & ~oor_q) ? mem_rdata : 32'h0;
                if (we_q & w_be_partial) begin
                    merge_d = w_merged;
                    state_d = C_ST_MERGE_WR;
                end else begin
                    state_d = C_ST_DONE;
                end
            end

            C_ST_MERGE_WR: begin
                state_d = C_ST_DONE;
            end

            C_ST_DONE: begin
                state_d = C_ST_IDLE;
            end

            default: begin
                state_d = C_ST_IDLE;
            end
        endcase

        // Counts back-to-back port-0 wins while port 1 is waiting; any gap in
        // the port-1 request restarts the budget.
        if (~m1_req) begin
            starve_cnt_d = 4'd0;
        end else if (w_granting) begin
            if (w_grant1) begin
                starve_cnt_d = 4'd0;
            end else if (starve_cnt_q != C_STARVE_LIMIT) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= C_ST_IDLE;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= 4'h0;
            addr_q       <= 12'h0;
            oor_q        <= 1'b0;
            wdata_q      <= 32'h0;
            rdata_q      <= 32'h0;
            merge_q      <= 32'h0;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            oor_q        <= oor_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            merge_q      <= merge_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Every output is held at zero while reset is high, so an access that is
    // cut short by reset can neither write memory nor complete.
    logic w_live;
    logic w_mem_phase;
    logic w_full_wr;
    logic w_done;

    assign w_live      = ~reset;
    assign w_mem_phase = (state_q == C_ST_ACCESS) | (state_q == C_ST_MERGE_WR);
    assign w_full_wr   = (state_q == C_ST_ACCESS) & we_q & w_be_full;
    assign w_done      = w_live & (state_q == C_ST_DONE);

    always_comb begin
        mem_addr  = 12'h0;
        mem_wdata = 32'h0;
        mem_we    = 1'b0;
        if (w_live & w_mem_phase) begin
            mem_addr = addr_q;
            if (w_full_wr) begin
                mem_wdata = wdata_q;
                mem_we    = ~oor_q;
            end else if (state_q == C_ST_MERGE_WR) begin
                mem_wdata = merge_q;
                mem_we    = ~oor_q;
            end
        end
    end

    assign busy     = w_live & (state_q != C_ST_IDLE);
    assign m0_ack   = w_done & ~port_q;
    assign m1_ack   = w_done &  port_q;
    assign err      = w_done & oor_q;
    assign m0_rdata = m0_ack ? rdata_q : 32'h0;
    assign m1_rdata = m1_ack ? rdata_q : 32'h0;

    // ------------------------------------------------------------------------
    // Optional write log
    // ------------------------------------------------------------------------
`ifdef DM_ARB_WRITE_LOG_EN
    logic [31:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (w_granting) begin
            pc_d = w_grant1 ? 32'h0 : m0_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= 32'h0;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            $display("%d@%h: *%h <= %h", $time, pc_q, {mem_addr, 2'b00}, mem_wdata);
        end
    end
`else
    // The issuing PC only feeds the write log.
    logic w_unused_pc;
    assign w_unused_pc = ^m0_pc;
`endif

endmodule
`default_nettype wire
